gate_exerciser: RTL and testbench

//  Sequential driver/checker for the combinational gate blocks in this codebase. It drives
//  the gate inputs, samples the gate output and compares it with the expected result.
//  On start it sweeps all 2^N_IN input vectors and waits SETTLE cycles per vector before sampling.
//  It counts mismatches and reports pass/fail. Sits beside a gate under test in lab or FPGA bring-up top levels.

---
 rtl/gate_exerciser_if.sv | 36 +++
 rtl/gate_exerciser.sv | 113 +++++++++++
 tb/tb_gate_exerciser.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_exerciser_if.sv
// rtl/gate_exerciser_if.sv - stimulus/result bundle between gate_exerciser and its controller
// Optional GATE_EXERCISER_FIRST_FAIL_EN adds fail_vec/fail_seen.
interface gate_exerciser_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [2:0]      op;
  logic [N_IN-1:0] drv;
  logic            dut_out;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
  logic [N_IN-1:0] fail_vec;
  logic            fail_seen;

  modport master (
    output start, op, dut_out,
    input  drv, busy, done, pass, err_cnt, fail_vec, fail_seen
  );
  modport slave (
    input  start, op, dut_out,
    output drv, busy, done, pass, err_cnt, fail_vec, fail_seen
  );
`else
  modport master (
    output start, op, dut_out,
    input  drv, busy, done, pass, err_cnt
  );
  modport slave (
    input  start, op, dut_out,
    output drv, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - sweeps all input vectors of a gate under test and counts mismatches
// Optional GATE_EXERCISER_FIRST_FAIL_EN captures the first failing vector.
module gate_exerciser #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  gate_exerciser_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // The sample cycle is one of the SETTLE+1 per-vector cycles, so the wait phase covers SETTLE-1 extra.
  localparam logic [7:0]      WAIT_LOAD = (SETTLE > 0) ? 8'(SETTLE - 1) : 8'd0;
  localparam logic [1:0]      NEXT_ST   = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
  localparam logic [N_IN-1:0] LAST_VEC  = '1;

  logic [1:0] state;
  logic [7:0] wcnt;
  logic [2:0] op_q;
  logic       and_r;
  logic       or_r;
  logic       xor_r;
  logic       expect_bit;
  logic       mismatch;

  assign and_r = &bus.drv;
  assign or_r  = |bus.drv;
  assign xor_r = ^bus.drv;

  always_comb begin
    expect_bit = and_r;
    case (op_q)
      3'd1:    expect_bit = or_r;
      3'd2:    expect_bit = xor_r;
      3'd3:    expect_bit = ~and_r;
      3'd4:    expect_bit = ~or_r;
      3'd5:    expect_bit = ~xor_r;
      default: expect_bit = and_r;
    endcase
  end

  assign mismatch = (bus.dut_out != expect_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      op_q        <= '0;
      bus.drv     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.pass    <= 1'b0;
      bus.err_cnt <= '0;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
      bus.fail_vec  <= '0;
      bus.fail_seen <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_cnt == '0);
          end
          if (bus.start) begin
            op_q        <= bus.op;
            bus.drv     <= '0;
            bus.err_cnt <= '0;
            bus.done    <= 1'b0;
            bus.pass    <= 1'b0;
            bus.busy    <= 1'b1;
            wcnt        <= WAIT_LOAD;
            state       <= NEXT_ST;
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
            bus.fail_vec  <= '0;
            bus.fail_seen <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          if (wcnt == 8'd0) state <= S_SAMPLE;
          else              wcnt  <= wcnt - 8'd1;
        end
        S_SAMPLE: begin
          if (mismatch) begin
            bus.err_cnt <= bus.err_cnt + (N_IN + 1)'(1);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
            if (!bus.fail_seen) begin
              bus.fail_vec  <= bus.drv;
              bus.fail_seen <= 1'b1;
            end
`endif
          end
          if (bus.drv == LAST_VEC) begin
            state <= S_DONE;
          end else begin
            bus.drv <= bus.drv + N_IN'(1);
            wcnt    <= WAIT_LOAD;
            state   <= NEXT_ST;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - scoreboard bench for gate_exerciser (optional GATE_EXERCISER_FIRST_FAIL_EN)
module tb_gate_exerciser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   mode_a = 0;
  int   gop_a = 0;

  typedef struct {
    int k;
    int err;
    int pas;
    int fvec;
    int fseen;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_exerciser_if #(.N_IN(2)) ifa ();
  gate_exerciser_if #(.N_IN(3)) ifb ();

  gate_exerciser #(.N_IN(2), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  gate_exerciser #(.N_IN(3), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  function automatic logic ref_gate(input int op, input int v, input int n);
    logic a;
    logic o;
    logic x;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    case (op)
      1:       return o;
      2:       return x;
      3:       return ~a;
      4:       return ~o;
      5:       return ~x;
      default: return a;
    endcase
  endfunction

  always_comb begin
    ifa.dut_out = 1'b0;
    if (mode_a == 2)      ifa.dut_out = 1'b1;
    else if (mode_a == 0) ifa.dut_out = ref_gate(gop_a, int'(ifa.drv), 2);
  end

  always_comb ifb.dut_out = ref_gate(2, int'(ifb.drv), 3);

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic start_a(input int op, input bit push, input int err, input int pas,
                         input int fvec, input int fseen);
    exp_t e;
    @(negedge clk);
    ifa.op    = 3'(op);
    ifa.start = 1'b1;
    if (push) begin
      e.k = cyc + 1; e.err = err; e.pas = pas; e.fvec = fvec; e.fseen = fseen;
      qa.push_back(e);
    end
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic start_b(input int op);
    exp_t e;
    @(negedge clk);
    ifb.op    = 3'(op);
    ifb.start = 1'b1;
    e.k = cyc + 1; e.err = 0; e.pas = 1; e.fvec = 0; e.fseen = 0;
    qb.push_back(e);
    @(negedge clk);
    ifb.start = 1'b0;
  endtask

  task automatic wait_done_a(input int bound);
    int n = 0;
    while (!ifa.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.done) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_done_b(input int bound);
    int n = 0;
    while (!ifb.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!ifb.done) chk("b_done_timeout", 0, 1);
  endtask

  // Scoreboard monitors: pop one expectation per rising done.
  initial begin
    logic dq;
    exp_t e;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.done && !dq && !rst) begin
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_latency", cyc - e.k, 9);
          chk("a_err_cnt", int'(ifa.err_cnt), e.err);
          chk("a_pass", int'(ifa.pass), e.pas);
          chk("a_busy_at_done", int'(ifa.busy), 0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
          chk("a_fail_seen", int'(ifa.fail_seen), e.fseen);
          chk("a_fail_vec", int'(ifa.fail_vec), e.fvec);
`endif
        end
      end
      dq = ifa.done;
    end
  end

  initial begin
    logic dq;
    exp_t e;
    dq = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.done && !dq && !rst) begin
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_latency", cyc - e.k, 9);
          chk("b_err_cnt", int'(ifb.err_cnt), e.err);
          chk("b_pass", int'(ifb.pass), e.pas);
          chk("b_drv_final", int'(ifb.drv), 7);
        end
      end
      dq = ifb.done;
    end
  end

  initial begin
    ifa.start = 1'b0; ifa.op = 3'd0;
    ifb.start = 1'b0; ifb.op = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_drv", int'(ifa.drv), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_pass", int'(ifa.pass), 0);
    chk("rst_err_cnt", int'(ifa.err_cnt), 0);
`ifdef GATE_EXERCISER_FIRST_FAIL_EN
    chk("rst_fail_seen", int'(ifa.fail_seen), 0);
`endif
    rst = 1'b0;

    // Ideal AND gate: each vector held two cycles.
    start_a(0, 1, 0, 1, 0, 0);
    chk("t1_busy", int'(ifa.busy), 1);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("t1_drv_hold", int'(ifa.drv), i / 2);
    end
    wait_done_a(40);

    // Stuck-at-0 then stuck-at-1 against AND.
    mode_a = 1;
    start_a(0, 1, 1, 0, 3, 1);
    wait_done_a(40);
    mode_a = 2;
    start_a(0, 1, 3, 0, 0, 1);
    wait_done_a(40);

    // Restart from DONE with an ideal NOR gate.
    mode_a = 0; gop_a = 4;
    start_a(4, 1, 0, 1, 0, 0);
    chk("t3_err_cleared", int'(ifa.err_cnt), 0);
    chk("t3_done_cleared", int'(ifa.done), 0);
    wait_done_a(40);

    // op change and start pulses mid-sweep and on the DONE-entry edge are ignored.
    gop_a = 0;
    start_a(0, 1, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    ifa.op = 3'd1; ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (4) @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    wait_done_a(40);
    repeat (3) @(negedge clk);
    chk("t4_done_held", int'(ifa.done), 1);
    chk("t4_busy_idle", int'(ifa.busy), 0);
    chk("t4_drv_held", int'(ifa.drv), 3);

    // Asynchronous reset during SAMPLE of vector 2.
    mode_a = 2;
    start_a(0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("t5_drv_pre_rst", int'(ifa.drv), 2);
    chk("t5_err_pre_rst", int'(ifa.err_cnt), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_drv", int'(ifa.drv), 0);
    chk("t5_rst_busy", int'(ifa.busy), 0);
    chk("t5_rst_done", int'(ifa.done), 0);
    chk("t5_rst_err_cnt", int'(ifa.err_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    mode_a = 0;
    start_a(0, 1, 0, 1, 0, 0);
    wait_done_a(40);

    // SETTLE=0, three-input XOR: one cycle per vector.
    start_b(2);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      chk("t6_drv_step", int'(ifb.drv), i);
    end
    wait_done_b(40);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
